// File: rtl/turn_pkg.sv
`default_nettype none
// ============================================================================
// Module : turn_pkg
// Desc   : Shared turn codes, FSM state encoding, counter widths and small
//          decode helpers for the turn-signal input conditioner.
// Rev    : 1.0  initial release
// ============================================================================
package turn_pkg;

  // Counter widths match the widths of the timing parameters they count to.
  localparam int DB_CNT_W = 20;
  localparam int PHASE_W  = 25;

  // Direction codes consumed by the downstream sequencer (2'b11 is never sent).
  localparam logic [1:0] TURN_NONE  = 2'b00;
  localparam logic [1:0] TURN_LEFT  = 2'b01;
  localparam logic [1:0] TURN_RIGHT = 2'b10;

  // Mode state machine encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEFT  = 3'd1,
    ST_RIGHT = 3'd2,
    ST_HAZ_L = 3'd3,
    ST_HAZ_R = 3'd4
  } state_t;

  // Steady-state mode implied by the debounced stalk contacts. Both contacts
  // closed at once can only be a stalk fault, so it reads as no direction.
  function automatic state_t stalk_state(input logic stalk_l, input logic stalk_r);
    state_t st;
    st = ST_IDLE;
    if (stalk_l && !stalk_r) begin
      st = ST_LEFT;
    end else if (stalk_r && !stalk_l) begin
      st = ST_RIGHT;
    end
    return st;
  endfunction

  // Direction code driven while in a given state; hazard sides reuse the
  // left/right codes so the sequencer needs no hazard-specific handling.
  function automatic logic [1:0] turn_code(input state_t st);
    logic [1:0] code;
    code = TURN_NONE;
    case (st)
      ST_LEFT, ST_HAZ_L:  code = TURN_LEFT;
      ST_RIGHT, ST_HAZ_R: code = TURN_RIGHT;
      default:            code = TURN_NONE;
    endcase
    return code;
  endfunction

  // True while hazard mode is latched, whichever side is currently lit.
  function automatic logic is_hazard(input state_t st);
    return (st == ST_HAZ_L) || (st == ST_HAZ_R);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_sync.sv
`default_nettype none
// ============================================================================
// Module : debounce_sync
// Desc   : Two-flop synchroniser followed by a stable-count debouncer for one
//          raw asynchronous contact. The debounced level only changes after
//          the synchronised input has differed from it for DEBOUNCE_CYCLES
//          consecutive clocks; any return to the current level restarts the
//          count, so shorter pulses never reach the output.
// Rev    : 1.0  initial release
// ============================================================================
module debounce_sync
  import turn_pkg::*;
#(
  parameter logic [DB_CNT_W-1:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  // Terminal count: the level flips on the clock where the count has already
  // reached this value, i.e. the DEBOUNCE_CYCLES-th consecutive differing sample.
  localparam logic [DB_CNT_W-1:0] CNT_LAST = DEBOUNCE_CYCLES - 1'b1;

  logic                sync_meta;
  logic                sync_q;
  logic [DB_CNT_W-1:0] count;

  // Two-flop synchroniser; sync_meta may go metastable and is never used directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
    end
  end

  // Stable-count debounce: count while the synced input disagrees, flip and clear at terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      level <= 1'b0;
    end else if (sync_q == level) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      level <= sync_q;
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/turn_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module : turn_input_ctrl
// Desc   : Turn-signal front end. Synchronises and debounces the left/right
//          stalk contacts and the hazard pushbutton, runs the left / right /
//          hazard mode machine and drives the registered direction code and
//          enable used by the downstream turn-signal sequencer.
// Rev    : 1.0  initial release
// ============================================================================
module turn_input_ctrl
  import turn_pkg::*;
#(
  parameter logic [DB_CNT_W-1:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [PHASE_W-1:0]  HAZ_PERIOD      = 25'd10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_left,
  input  logic       sw_right,
  input  logic       btn_hazard,
  output logic [1:0] turn,
  output logic       hazard,
  output logic       hazard_mode
);

  // Last phase count of a hazard side; the side flips on the clock after it.
  localparam logic [PHASE_W-1:0] PHASE_LAST = HAZ_PERIOD - 1'b1;

  logic               db_left;
  logic               db_right;
  logic               db_haz;
  logic               db_haz_q;
  logic               haz_evt;
  state_t             state;
  state_t             state_next;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_next;

  // --------------------------------------------------------------------------
  // Input conditioning: one synchroniser + debouncer per raw contact.
  // --------------------------------------------------------------------------
  debounce_sync #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_left (
    .clk   (clk),
    .rst   (rst),
    .raw   (sw_left),
    .level (db_left)
  );

  debounce_sync #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_right (
    .clk   (clk),
    .rst   (rst),
    .raw   (sw_right),
    .level (db_right)
  );

  debounce_sync #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_hazard (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_hazard),
    .level (db_haz)
  );

  // Previous debounced button level, so a press is seen once and a release never.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_haz_q <= 1'b0;
    end else begin
      db_haz_q <= db_haz;
    end
  end

  // One-cycle toggle request on the debounced press edge.
  assign haz_evt = db_haz & ~db_haz_q;

  // Next mode and hazard phase: a press always wins over a stalk change in the same cycle.
  always_comb begin
    state_next = state;
    phase_next = phase;
    case (state)
      ST_IDLE, ST_LEFT, ST_RIGHT: begin
        phase_next = '0;
        if (haz_evt) begin
          state_next = ST_HAZ_L;
        end else begin
          state_next = stalk_state(db_left, db_right);
        end
      end
      ST_HAZ_L, ST_HAZ_R: begin
        if (haz_evt) begin
          // Leaving hazard lands directly on whatever the stalk says right now.
          state_next = stalk_state(db_left, db_right);
          phase_next = '0;
        end else if (phase == PHASE_LAST) begin
          phase_next = '0;
          state_next = (state == ST_HAZ_L) ? ST_HAZ_R : ST_HAZ_L;
        end else begin
          // Stalk movement is deliberately ignored while hazard is latched.
          phase_next = phase + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        phase_next = '0;
      end
    endcase
  end

  // Mode register with outputs decoded from the next state, so they change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      phase       <= '0;
      turn        <= TURN_NONE;
      hazard      <= 1'b0;
      hazard_mode <= 1'b0;
    end else begin
      state       <= state_next;
      phase       <= phase_next;
      turn        <= turn_code(state_next);
      hazard      <= (state_next != ST_IDLE);
      hazard_mode <= is_hazard(state_next);
    end
  end

endmodule
`default_nettype wire
